column_shift_loader: RTL and testbench

COLUMN_SHIFT_LOADER -- requirements
Module: column_shift_loader

---
 rtl/column_shift_loader.sv | 129 ++++++++++++
 tb/tb_column_shift_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/column_shift_loader.sv
// Triangular column shift-register loader: WIDTH beats fill a frame, which is then held until the consumer takes it.
// Optional feature: define SHREG_COL_PARITY_EN for per-column parity registers (col_parity is tied to 0 otherwise).
module column_shift_loader #(
    parameter  int WIDTH = 28,
    localparam int COLS  = 2*WIDTH-1,
    localparam int TOTAL = WIDTH*WIDTH,
    localparam int CW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [COLS-1:0]  in_bits,
    output logic             in_ready,
    output logic [TOTAL-1:0] col_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    beat_cnt,
    output logic [COLS-1:0]  col_parity
);

    // state | meaning
    // FILL  | accepting beats, beat_cnt < WIDTH
    // HOLD  | complete frame presented, waiting for out_ready
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    function automatic int col_h(input int c);
        return (c+1 < COLS-c) ? c+1 : COLS-c;
    endfunction

    function automatic int col_base(input int c);
        int s;
        s = 0;
        for (int k = 0; k < c; k++) s += col_h(k);
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [TOTAL-1:0] col_q, col_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TOTAL-1:0] shifted;
    logic             accept;

`ifdef SHREG_COL_PARITY_EN
    logic [COLS-1:0]  par_shift, par_d, par_q;
`endif

    // Each column inserts its new bit at the bottom and drops its top bit.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int H = col_h(c);
        localparam int B = col_base(c);
        if (H == 1) begin : g_one
            assign shifted[B] = in_bits[c];
        end else begin : g_many
            assign shifted[B +: H] = {col_q[B +: H-1], in_bits[c]};
        end
`ifdef SHREG_COL_PARITY_EN
        assign par_shift[c] = ^shifted[B +: H];
`endif
    end

    assign accept = in_valid && (state_q == FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (in_valid && cnt_q == CW'(WIDTH-1)) state_d = HOLD;
                HOLD:    if (out_ready) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == HOLD);
    end

    // flush outranks both a same-cycle beat and a same-cycle handshake.
    always_comb begin
        col_d = col_q;
        cnt_d = cnt_q;
        if (flush) begin
            col_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            col_d = shifted;
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == HOLD && out_ready) begin
            cnt_d = '0;
        end
    end

`ifdef SHREG_COL_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (flush)       par_d = '0;
        else if (accept) par_d = par_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) par_q <= '0;
        else     par_q <= par_d;
    end

    assign col_parity = par_q;
`else
    assign col_parity = '0;
`endif

    assign col_bits = col_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_column_shift_loader.sv
// Directed bench for column_shift_loader at WIDTH=4 with a beat-history reference model and frame scoreboard.
// Parity expectations follow SHREG_COL_PARITY_EN when it is defined for the build.
module tb_column_shift_loader;

    localparam int W     = 4;
    localparam int COLS  = 2*W-1;
    localparam int TOTAL = W*W;
    localparam int CW    = $clog2(W+1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [COLS-1:0]  in_bits;
    logic             in_ready;
    logic [TOTAL-1:0] col_bits;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    beat_cnt;
    logic [COLS-1:0]  col_parity;

    int total = 0;
    int bad   = 0;

    logic [COLS-1:0]  hist[$];
    logic [TOTAL-1:0] sb[$];
    int               cnt_m  = 0;
    bit               hold_m = 0;
    logic             prev_ov = 0;

    column_shift_loader #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_bits    (in_bits),
        .in_ready   (in_ready),
        .col_bits   (col_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .beat_cnt   (beat_cnt),
        .col_parity (col_parity)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int h_of(input int c);
        return (c+1 < COLS-c) ? c+1 : COLS-c;
    endfunction

    function automatic int base_of(input int c);
        int s;
        s = 0;
        for (int k = 0; k < c; k++) s += h_of(k);
        return s;
    endfunction

    // Bit j of column c is the beat accepted j beats before the latest one.
    function automatic logic [TOTAL-1:0] exp_cols();
        logic [TOTAL-1:0] r;
        int b, idx;
        r = '0;
        b = 0;
        for (int c = 0; c < COLS; c++) begin
            for (int j = 0; j < h_of(c); j++) begin
                idx = hist.size() - 1 - j;
                if (idx >= 0) r[b+j] = hist[idx][c];
            end
            b += h_of(c);
        end
        return r;
    endfunction

    function automatic logic [COLS-1:0] exp_par(input logic [TOTAL-1:0] cb);
        logic [COLS-1:0] p;
        p = '0;
`ifdef SHREG_COL_PARITY_EN
        for (int c = 0; c < COLS; c++)
            for (int j = 0; j < h_of(c); j++)
                p[c] = p[c] ^ cb[base_of(c)+j];
`else
        if (cb != cb) p = '1;
`endif
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [TOTAL-1:0] ec;
        logic [TOTAL-1:0] f;
        ec = exp_cols();
        chk("in_ready",   64'(in_ready),   64'(!hold_m));
        chk("out_valid",  64'(out_valid),  64'(hold_m));
        chk("beat_cnt",   64'(beat_cnt),   64'(cnt_m));
        chk("col_bits",   64'(col_bits),   64'(ec));
        chk("col_parity", 64'(col_parity), 64'(exp_par(ec)));
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_frame", 64'(1), 64'(0));
            end else begin
                f = sb.pop_front();
                chk("sb_frame", 64'(col_bits), 64'(f));
            end
        end
        prev_ov = out_valid;
    endtask

    task automatic cycle(input logic v, input logic [COLS-1:0] bits, input logic ordy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_bits   = bits;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        if (r || fl) begin
            hist.delete();
            cnt_m  = 0;
            hold_m = 0;
        end else if (!hold_m && v) begin
            hist.push_back(bits);
            if (hist.size() > W) void'(hist.pop_front());
            cnt_m++;
            if (cnt_m == W) begin
                hold_m = 1;
                sb.push_back(exp_cols());
            end
        end else if (hold_m && ordy) begin
            hold_m = 0;
            cnt_m  = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;

        cycle(0, 7'h00, 0, 0, 1);
        cycle(1, 7'h7F, 1, 1, 1);
        chk("reset_col_bits", 64'(col_bits), 64'(0));

        // Four all-ones beats fill every column.
        for (int i = 0; i < W; i++) cycle(1, 7'h7F, 0, 0, 0);
        chk("full_ones", 64'(col_bits), 64'(16'hFFFF));

        // Held frame ignores in_valid and stays frozen until out_ready.
        for (int i = 0; i < 5; i++) cycle(1, 7'($urandom_range(127, 0)), 0, 0, 0);
        chk("hold_frozen", 64'(col_bits), 64'(16'hFFFF));
        cycle(1, 7'h55, 1, 0, 0);
        chk("release_cnt", 64'(beat_cnt), 64'(0));

        cycle(1, 7'h01, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        chk("col0_overwritten", 64'(col_bits[0]), 64'(0));
        chk("col3_zero", 64'(col_bits[6 +: 4]), 64'(4'b0000));
        cycle(0, 7'h00, 1, 0, 0);
        cycle(1, 7'h08, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 7'h00, 0, 0, 0);
        chk("col3_oldest", 64'(col_bits[6 +: 4]), 64'(4'b1000));
        cycle(0, 7'h00, 1, 0, 0);

        // Flush beats a same-cycle accepted beat.
        cycle(1, 7'h2A, 0, 0, 0);
        cycle(1, 7'h15, 0, 0, 0);
        cycle(1, 7'h7F, 0, 1, 0);
        chk("flush_clears", 64'(col_bits), 64'(0));

        // Stall cycles interleaved with beats.
        for (int i = 0; i < 2*W; i++)
            cycle(1'(i % 2 == 0), 7'($urandom_range(127, 0)), 0, 0, 0);
        chk("toggle_complete", 64'(out_valid), 64'(1));
        cycle(0, 7'h00, 1, 0, 0);

        cycle(1, 7'h7F, 0, 0, 0);
        cycle(1, 7'h7F, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        cycle(1, 7'h00, 0, 0, 0);
        chk("two_ones_col3", 64'(col_bits[6 +: 4]), 64'(4'b1100));

        // Flush wins over a same-cycle handshake in HOLD.
        cycle(0, 7'h00, 1, 1, 0);

        // Reset mid-frame discards partial data.
        cycle(1, 7'h33, 0, 0, 0);
        cycle(1, 7'h4C, 0, 0, 0);
        cycle(1, 7'h7F, 0, 1, 1);
        for (int i = 0; i < W-1; i++) cycle(1, 7'($urandom_range(127, 0)), 0, 0, 0);
        cycle(1, 7'h6E, 0, 0, 0);
        cycle(0, 7'h00, 1, 0, 0);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
